// File: rtl/data_mem_responder.sv
// Purpose: data-memory responder for the 3-stage pipeline; byte/half/word loads and stores with RISC-V extension.
// Latency: response (rvalid / store commit) WAIT_CYCLES+1 cycles after a legal request is accepted.
// Backpressure: combinational stall holds the pipeline from acceptance through the last WAIT cycle; illegal requests get a one-cycle misalign_err instead.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   read_en, write_en  load / store request (sampled only in IDLE)
//   funct3             access width and sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   addr, wdata        byte address and right-aligned store data
//   rdata, rvalid      extended load result and its one-cycle valid pulse
//   stall              holds PC / pipeline registers while the access is in flight
//   misalign_err       one-cycle pulse when a request is rejected
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        stall,
    output logic        misalign_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;

    logic [31:0] mem [DEPTH_WORDS];

    // Request captured at acceptance
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_funct3;
    logic        lat_store;

    // Request decode
    logic req, req_legal, width_ok, align_ok;
    logic accept, reject, go_resp;

    always_comb begin
        width_ok = 1'b0;
        align_ok = 1'b0;
        case (funct3)
            3'b000: begin width_ok = 1'b1;    align_ok = 1'b1;              end
            3'b100: begin width_ok = read_en; align_ok = 1'b1;              end
            3'b001: begin width_ok = 1'b1;    align_ok = ~addr[0];          end
            3'b101: begin width_ok = read_en; align_ok = ~addr[0];          end
            3'b010: begin width_ok = 1'b1;    align_ok = (addr[1:0] == 2'b00); end
            default: begin width_ok = 1'b0;   align_ok = 1'b0;              end
        endcase
    end

    assign req       = read_en | write_en;
    // Both enables at once is not a well-formed instruction, so XOR rather than OR.
    assign req_legal = (read_en ^ write_en) & width_ok & align_ok;
    assign accept    = (state == IDLE) & req_legal;
    assign reject    = (state == IDLE) & req & ~req_legal;

    // Next-state logic
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        go_resp      = 1'b0;
        case (state)
            IDLE: begin
                if (req_legal) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                        go_resp   = 1'b1;
                    end else begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = 4'd0;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt    = RESP;
                    go_resp      = 1'b1;
                    wait_cnt_nxt = 4'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign stall = accept | (state == WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_addr   <= addr;
            lat_wdata  <= wdata;
            lat_funct3 <= funct3;
            lat_store  <= write_en;
        end
    end

    // With zero wait the response edge is the acceptance edge itself, so the
    // access must be able to use the live inputs rather than the latched copy.
    logic [31:0] acc_addr, acc_wdata;
    logic [2:0]  acc_funct3;
    logic        acc_store;

    assign acc_addr   = (state == IDLE) ? addr     : lat_addr;
    assign acc_wdata  = (state == IDLE) ? wdata    : lat_wdata;
    assign acc_funct3 = (state == IDLE) ? funct3   : lat_funct3;
    assign acc_store  = (state == IDLE) ? write_en : lat_store;

    // Upper address bits are deliberately ignored: accesses wrap around the array.
    logic [AW-1:0] word_idx;
    logic          unused_addr_bits;
    assign word_idx         = acc_addr[AW+1:2];
    assign unused_addr_bits = ^acc_addr;

    // Store lanes: data is replicated across lanes so only the enable mask needs the offset.
    logic [3:0]  lane_en;
    logic [31:0] lane_dat;

    always_comb begin
        case (acc_funct3[1:0])
            2'b00: begin
                lane_en  = 4'b0001 << acc_addr[1:0];
                lane_dat = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                lane_en  = acc_addr[1] ? 4'b1100 : 4'b0011;
                lane_dat = {2{acc_wdata[15:0]}};
            end
            default: begin
                lane_en  = 4'b1111;
                lane_dat = acc_wdata;
            end
        endcase
    end

    // Reset kills a store that would otherwise commit on this same edge.
    always_ff @(posedge clk) begin
        if (!rst && go_resp && acc_store) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][8*i +: 8] <= lane_dat[8*i +: 8];
                end
            end
        end
    end

    // Load path: select and extend
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic        sign_ext;
    logic [31:0] load_val;

    assign rd_word  = mem[word_idx];
    assign rd_byte  = rd_word[{acc_addr[1:0], 3'b000} +: 8];
    assign rd_half  = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    assign sign_ext = ~acc_funct3[2];

    always_comb begin
        case (acc_funct3[1:0])
            2'b00:   load_val = {{24{sign_ext & rd_byte[7]}}, rd_byte};
            2'b01:   load_val = {{16{sign_ext & rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata        <= 32'd0;
            rvalid       <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            rvalid       <= go_resp & ~acc_store;
            misalign_err <= reject;
            if (go_resp && !acc_store) begin
                rdata <= load_val;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int MEM_BYTES = 4096;
    localparam logic [1:0] K_ST = 2'd0, K_LD = 2'd1, K_ILL = 2'd2;

    logic clk;
    logic rst;

    // Index 1: WAIT_CYCLES=1 instance, index 0: WAIT_CYCLES=0 instance
    logic        re_s [2];
    logic        we_s [2];
    logic [2:0]  f3_s [2];
    logic [31:0] a_s  [2];
    logic [31:0] wd_s [2];
    logic [31:0] rd_s [2];
    logic        rv_s [2];
    logic        st_s [2];
    logic        er_s [2];

    int total = 0;
    int bad   = 0;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .read_en(re_s[1]), .write_en(we_s[1]), .funct3(f3_s[1]),
        .addr(a_s[1]), .wdata(wd_s[1]), .rdata(rd_s[1]), .rvalid(rv_s[1]),
        .stall(st_s[1]), .misalign_err(er_s[1])
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .read_en(re_s[0]), .write_en(we_s[0]), .funct3(f3_s[0]),
        .addr(a_s[0]), .wdata(wd_s[0]), .rdata(rd_s[0]), .rvalid(rv_s[0]),
        .stall(st_s[0]), .misalign_err(er_s[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (byte-addressed memory of dut1) ----------------
    logic [7:0] mb [MEM_BYTES];

    function automatic logic model_legal(input logic re, input logic we,
                                         input logic [2:0] f3, input logic [31:0] a);
        if (re == we) return 1'b0;
        case (f3)
            3'd0: return 1'b1;
            3'd4: return re;
            3'd1: return !a[0];
            3'd5: return re && !a[0];
            3'd2: return a[1:0] == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int ba = int'(a % MEM_BYTES);
        int nbytes = 1 << f3[1:0];
        longint v = 0;
        for (int i = nbytes - 1; i >= 0; i--) v = v * 256 + longint'(mb[ba + i]);
        if (!f3[2] && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
            v = v - (longint'(1) << (8 * nbytes));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int ba = int'(a % MEM_BYTES);
        int nbytes = 1 << f3[1:0];
        for (int i = 0; i < nbytes; i++) mb[ba + i] = wd[8*i +: 8];
    endtask

    // ---------------- driver: behaves like the pipeline, holding the request while stalled ----------------
    task automatic run_op(input int sel, input logic re, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int n_stall, output int rv_cyc, output int n_rv,
                          output int er_cyc, output int n_er, output logic [31:0] rd);
        logic prev_stall = 1'b1;
        n_stall = 0; rv_cyc = -1; n_rv = 0; er_cyc = -1; n_er = 0; rd = '0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (prev_stall) begin
                re_s[sel] = re; we_s[sel] = we; f3_s[sel] = f3; a_s[sel] = a; wd_s[sel] = wd;
            end else begin
                re_s[sel] = 1'b0; we_s[sel] = 1'b0;
            end
            #1;
            if (st_s[sel]) n_stall++;
            if (rv_s[sel]) begin
                n_rv++;
                if (rv_cyc < 0) begin rv_cyc = c; rd = rd_s[sel]; end
            end
            if (er_s[sel]) begin
                n_er++;
                if (er_cyc < 0) er_cyc = c;
            end
            prev_stall = st_s[sel];
        end
        re_s[sel] = 1'b0; we_s[sel] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            re_s[s] = 0; we_s[s] = 0; f3_s[s] = 0; a_s[s] = 0; wd_s[s] = 0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            total++;
            if (rd_s[s] !== 32'd0) begin bad++; $display("FAIL reset_rdata dut%0d got=%h want=0", s, rd_s[s]); end
            total++;
            if (rv_s[s] !== 1'b0) begin bad++; $display("FAIL reset_rvalid dut%0d got=%b want=0", s, rv_s[s]); end
            total++;
            if (er_s[s] !== 1'b0) begin bad++; $display("FAIL reset_err dut%0d got=%b want=0", s, er_s[s]); end
            total++;
            if (st_s[s] !== 1'b0) begin bad++; $display("FAIL reset_stall dut%0d got=%b want=0", s, st_s[s]); end
        end
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic        re;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  kind;
        logic [31:0] exp;
    } op_t;

    op_t tbl [23];

    task automatic fill_table;
        // Word 0x10 layout and sub-word accesses, with WAIT_CYCLES=1
        tbl[0]  = '{1'b0, 1'b1, 3'b010, 32'h10,   32'hDEADBEEF, K_ST,  32'h0};
        tbl[1]  = '{1'b1, 1'b0, 3'b010, 32'h10,   32'h0,        K_LD,  32'hDEADBEEF};
        tbl[2]  = '{1'b1, 1'b0, 3'b000, 32'h13,   32'h0,        K_LD,  32'hFFFFFFDE};
        tbl[3]  = '{1'b1, 1'b0, 3'b100, 32'h13,   32'h0,        K_LD,  32'h000000DE};
        tbl[4]  = '{1'b1, 1'b0, 3'b001, 32'h12,   32'h0,        K_LD,  32'hFFFFDEAD};
        tbl[5]  = '{1'b1, 1'b0, 3'b101, 32'h10,   32'h0,        K_LD,  32'h0000BEEF};
        tbl[6]  = '{1'b0, 1'b1, 3'b000, 32'h11,   32'hAAAAAA55, K_ST,  32'h0};
        tbl[7]  = '{1'b1, 1'b0, 3'b010, 32'h10,   32'h0,        K_LD,  32'hDEAD55EF};
        tbl[8]  = '{1'b0, 1'b1, 3'b001, 32'h12,   32'hFFFF1234, K_ST,  32'h0};
        tbl[9]  = '{1'b1, 1'b0, 3'b010, 32'h10,   32'h0,        K_LD,  32'h123455EF};
        tbl[10] = '{1'b1, 1'b0, 3'b010, 32'h11,   32'h0,        K_ILL, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 3'b001, 32'h13,   32'h0,        K_ILL, 32'h0};
        tbl[12] = '{1'b0, 1'b1, 3'b100, 32'h10,   32'h0,        K_ILL, 32'h0};
        tbl[13] = '{1'b1, 1'b1, 3'b010, 32'h10,   32'h0,        K_ILL, 32'h0};
        tbl[14] = '{1'b1, 1'b0, 3'b010, 32'h10,   32'h0,        K_LD,  32'h123455EF};
        tbl[15] = '{1'b0, 1'b1, 3'b010, 32'h1000, 32'hA5A5A5A5, K_ST,  32'h0};
        tbl[16] = '{1'b1, 1'b0, 3'b010, 32'h0,    32'h0,        K_LD,  32'hA5A5A5A5};
        // WAIT_CYCLES=0 instance
        tbl[17] = '{1'b0, 1'b1, 3'b010, 32'h40,   32'h0BADF00D, K_ST,  32'h0};
        tbl[18] = '{1'b1, 1'b0, 3'b010, 32'h40,   32'h0,        K_LD,  32'h0BADF00D};
        tbl[19] = '{1'b1, 1'b0, 3'b001, 32'h42,   32'h0,        K_LD,  32'h00000BAD};
        tbl[20] = '{1'b1, 1'b0, 3'b000, 32'h40,   32'h0,        K_LD,  32'h0000000D};
        tbl[21] = '{1'b1, 1'b0, 3'b010, 32'h42,   32'h0,        K_ILL, 32'h0};
        tbl[22] = '{1'b1, 1'b0, 3'b100, 32'h43,   32'h0,        K_LD,  32'h0000000B};
    endtask

    task automatic test_directed(input int sel, input int w, input int lo, input int hi);
        int n_stall, rv_cyc, n_rv, er_cyc, n_er, exp_stall;
        logic [31:0] rd;
        for (int i = lo; i <= hi; i++) begin
            run_op(sel, tbl[i].re, tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd,
                   n_stall, rv_cyc, n_rv, er_cyc, n_er, rd);
            exp_stall = (tbl[i].kind == K_ILL) ? 0 : w + 1;
            total++;
            if (n_stall !== exp_stall) begin
                bad++; $display("FAIL dir%0d_stall_cycles got=%0d want=%0d", i, n_stall, exp_stall);
            end
            if (tbl[i].kind == K_LD) begin
                total++;
                if (n_rv !== 1 || rv_cyc !== w + 1) begin
                    bad++; $display("FAIL dir%0d_rvalid got count=%0d at=%0d want count=1 at=%0d", i, n_rv, rv_cyc, w + 1);
                end
                total++;
                if (rd !== tbl[i].exp) begin
                    bad++; $display("FAIL dir%0d_rdata got=%h want=%h", i, rd, tbl[i].exp);
                end
            end else begin
                total++;
                if (n_rv !== 0) begin bad++; $display("FAIL dir%0d_rvalid got count=%0d want=0", i, n_rv); end
            end
            total++;
            if (tbl[i].kind == K_ILL) begin
                if (n_er !== 1 || er_cyc !== 1) begin
                    bad++; $display("FAIL dir%0d_misalign got count=%0d at=%0d want count=1 at=1", i, n_er, er_cyc);
                end
            end else if (n_er !== 0) begin
                bad++; $display("FAIL dir%0d_misalign got count=%0d want=0", i, n_er);
            end
        end
    endtask

    task automatic test_reset_in_wait;
        int n_stall, rv_cyc, n_rv, er_cyc, n_er;
        logic [31:0] rd;
        run_op(1, 1'b0, 1'b1, 3'b010, 32'h20, 32'h11223344, n_stall, rv_cyc, n_rv, er_cyc, n_er, rd);
        total++;
        if (n_stall !== 2) begin bad++; $display("FAIL rw_prior_store stall got=%0d want=2", n_stall); end
        @(negedge clk);
        re_s[1] = 1'b0; we_s[1] = 1'b1; f3_s[1] = 3'b010; a_s[1] = 32'h20; wd_s[1] = 32'hCAFEF00D;
        #1;
        total++;
        if (st_s[1] !== 1'b1) begin bad++; $display("FAIL rw_accept_stall got=%b want=1", st_s[1]); end
        @(negedge clk);
        #1;
        total++;
        if (st_s[1] !== 1'b1) begin bad++; $display("FAIL rw_wait_stall got=%b want=1", st_s[1]); end
        rst = 1'b1;
        we_s[1] = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (st_s[1] !== 1'b0 || rv_s[1] !== 1'b0) begin
            bad++; $display("FAIL rw_after_reset got stall=%b rvalid=%b want 0 0", st_s[1], rv_s[1]);
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            total++;
            if (st_s[1] !== 1'b0 || rv_s[1] !== 1'b0) begin
                bad++; $display("FAIL rw_idle got stall=%b rvalid=%b want 0 0", st_s[1], rv_s[1]);
            end
        end
        run_op(1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, n_stall, rv_cyc, n_rv, er_cyc, n_er, rd);
        total++;
        if (n_rv !== 1 || rv_cyc !== 2) begin
            bad++; $display("FAIL rw_reload_rvalid got count=%0d at=%0d want count=1 at=2", n_rv, rv_cyc);
        end
        total++;
        if (rd !== 32'h11223344) begin bad++; $display("FAIL rw_reload_rdata got=%h want=11223344", rd); end
    endtask

    task automatic test_random;
        int n_stall, rv_cyc, n_rv, er_cyc, n_er, pick, exp_stall;
        logic [31:0] rd, a, wd, exp;
        logic [2:0]  f3;
        logic        re, we, legal;
        logic [1:0]  kind;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            a  = (32'($urandom) << 12) | 32'(i * 4);
            run_op(1, 1'b0, 1'b1, 3'b010, a, wd, n_stall, rv_cyc, n_rv, er_cyc, n_er, rd);
            model_store(3'b010, a, wd);
            total++;
            if (n_stall !== 2 || n_rv !== 0 || n_er !== 0) begin
                bad++; $display("FAIL rnd_init%0d got stall=%0d rv=%0d err=%0d want 2 0 0", i, n_stall, n_rv, n_er);
            end
        end
        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 9);
            re = (pick < 5) || (pick == 9);
            we = (pick >= 5);
            f3 = 3'($urandom_range(0, 7));
            a  = (32'($urandom) << 12) | 32'($urandom_range(0, 63));
            wd = $urandom;
            legal = model_legal(re, we, f3, a);
            kind  = !legal ? K_ILL : (we ? K_ST : K_LD);
            exp   = (kind == K_LD) ? model_load(f3, a) : 32'h0;
            run_op(1, re, we, f3, a, wd, n_stall, rv_cyc, n_rv, er_cyc, n_er, rd);
            if (kind == K_ST) model_store(f3, a, wd);
            exp_stall = (kind == K_ILL) ? 0 : 2;
            total++;
            if (n_stall !== exp_stall) begin
                bad++; $display("FAIL rnd%0d_stall re=%b we=%b f3=%0d a=%h got=%0d want=%0d", n, re, we, f3, a, n_stall, exp_stall);
            end
            total++;
            if (n_rv !== ((kind == K_LD) ? 1 : 0)) begin
                bad++; $display("FAIL rnd%0d_rvalid re=%b we=%b f3=%0d a=%h got=%0d", n, re, we, f3, a, n_rv);
            end
            total++;
            if (n_er !== ((kind == K_ILL) ? 1 : 0)) begin
                bad++; $display("FAIL rnd%0d_misalign re=%b we=%b f3=%0d a=%h got=%0d", n, re, we, f3, a, n_er);
            end
            if (kind == K_LD) begin
                total++;
                if (rd !== exp) begin
                    bad++; $display("FAIL rnd%0d_rdata f3=%0d a=%h got=%h want=%h", n, f3, a, rd, exp);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        fill_table();
        test_reset();
        test_directed(1, 1, 0, 16);
        test_directed(0, 0, 17, 22);
        test_reset_in_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
